// File: rtl/aes_pkg.sv
// Shared ShiftRows definitions: block sizing, row offsets and the byte permutation.
package aes_pkg;

  typedef enum logic {IN_FILL  = 1'b0, IN_STALL  = 1'b1} in_state_e;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_DRAIN = 1'b1} out_state_e;

  function automatic int unsigned BYTES(input int unsigned nb);
    return 32'd4 * nb;
  endfunction

  // Rijndael row rotation; the 256-bit block skips offset 2.
  function automatic int unsigned row_off(input int unsigned nb, input int unsigned r);
    if (nb == 32'd8 && r >= 32'd2) return r + 32'd1;
    return r;
  endfunction

  // Column-major source index feeding output byte j.
  function automatic int unsigned sr_src_idx(input int unsigned nb, input logic inv,
                                             input int unsigned j);
    int unsigned r;
    int unsigned c;
    int unsigned off;
    int unsigned sc;
    r   = j % 32'd4;
    c   = j / 32'd4;
    off = row_off(nb, r);
    sc  = inv ? (c + nb - off) % nb : (c + off) % nb;
    return sc * 32'd4 + r;
  endfunction

endpackage

// File: rtl/shift_rows_src_index.sv
// Combinational output-position to source-position map for one ShiftRows block.
module shift_rows_src_index
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4,
  localparam int unsigned CW = $clog2(BYTES(NB))
) (
  input  logic [CW-1:0] j_i,
  input  logic          inv_i,
  output logic [CW-1:0] src_c
);

  always_comb src_c = CW'(sr_src_idx(NB, inv_i, 32'(j_i)));

endmodule

// File: rtl/shift_rows_stream.sv
// Byte-serial ShiftRows engine: ping-pong block buffers, permuted on the read side.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       in_inv,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       out_inv
);

  localparam int unsigned   NBYTES   = BYTES(NB);
  localparam int unsigned   CW       = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  logic [7:0]    mem_q [2][NBYTES];
  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  in_state_e     in_state_q, in_state_d;
  out_state_e    out_state_q, out_state_d;
  logic [7:0]    out_byte_q, out_byte_d;
  logic          out_last_q, out_last_d;
  logic          out_inv_q, out_inv_d;
  logic          in_fire, out_fire;
  logic [CW-1:0] src_idx;

  assign in_ready  = (in_state_q == IN_FILL);
  assign out_valid = (out_state_q == OUT_DRAIN);
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign out_inv   = out_inv_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  shift_rows_src_index #(.NB(NB)) u_rd_idx (
    .j_i  (rd_cnt_d),
    .inv_i(mode_q[rd_bank_d]),
    .src_c(src_idx)
  );

  // Fill and drain always touch opposite banks, so both updates may land together.
  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;

    if (in_fire) begin
      if (wr_cnt_q == '0) mode_d[wr_bank_q] = in_inv;
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (out_fire) begin
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end

    in_state_d  = full_d[wr_bank_d] ? IN_STALL : IN_FILL;
    out_state_d = full_d[rd_bank_d] ? OUT_DRAIN : OUT_IDLE;

    // Output byte is looked up from the next read position so it is ready with out_valid.
    out_byte_d = '0;
    out_last_d = 1'b0;
    out_inv_d  = 1'b0;
    if (full_d[rd_bank_d]) begin
      out_byte_d = mem_q[rd_bank_d][src_idx];
      out_last_d = (rd_cnt_d == LAST_IDX);
      out_inv_d  = mode_q[rd_bank_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      mode_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      in_state_q  <= IN_STALL;
      out_state_q <= OUT_IDLE;
      out_byte_q  <= '0;
      out_last_q  <= 1'b0;
      out_inv_q   <= 1'b0;
    end else begin
      full_q      <= full_d;
      mode_q      <= mode_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      out_inv_q   <= out_inv_d;
    end
  end

  // Bank storage carries no reset; the full flags decide what is live.
  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wr_bank_q][wr_cnt_q] <= in_byte;
  end

endmodule
